// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared constants for the execute-stage multiply/divide sequencer:
// op encodings, FSM state encoding and iteration-counter width.
package ex_muldiv_ctrl_pkg;

    localparam int LEN   = 32;
    localparam int CNT_W = $clog2(LEN);

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiply / restoring divide loop
// on the {acc, lo} working pair.
module muldiv_step #(
    parameter int len = 32
) (
    input  logic           is_div,
    input  logic [len-1:0] acc,
    input  logic [len-1:0] lo,
    input  logic [len-1:0] opnd,
    output logic [len-1:0] nxt_acc,
    output logic [len-1:0] nxt_lo
);

    logic [len:0] sum;
    logic [len:0] rem_sh;
    logic [len:0] diff;

    always_comb begin
        sum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc, lo[len-1]};
        diff   = rem_sh - {1'b0, opnd};
        if (is_div) begin
            // remainder < divisor keeps the trial result within len+1 bits
            if (!diff[len]) begin
                nxt_acc = diff[len-1:0];
                nxt_lo  = {lo[len-2:0], 1'b1};
            end else begin
                nxt_acc = rem_sh[len-1:0];
                nxt_lo  = {lo[len-2:0], 1'b0};
            end
        end else begin
            nxt_acc = sum[len:1];
            nxt_lo  = {sum[0], lo[len-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO, stall and MTHI/MTLO.
// Works on magnitudes; signs are applied in the FIX state.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int len      = LEN,
    parameter int NB_MD_OP = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [NB_MD_OP-1:0] i_op,
    input  logic [len-1:0]      i_dato1,
    input  logic [len-1:0]      i_dato2,
    input  logic                i_flush,
    input  logic                i_wr_hi,
    input  logic                i_wr_lo,
    input  logic [len-1:0]      i_wdata,
    output logic [len-1:0]      o_hi,
    output logic [len-1:0]      o_lo,
    output logic                o_busy,
    output logic                o_stall,
    output logic                o_done
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [len-1:0]   acc, wlo, opnd, nxt_acc, nxt_lo;
    logic [len-1:0]   hi_q, lo_q;
    logic             op_div, neg_q, neg_r, done_q;

    logic             is_div, is_signed, s1, s2, div_zero, go;
    logic [len-1:0]   a_mag, b_mag;
    logic [2*len-1:0] prod;

    always_comb begin
        is_div    = (i_op == MD_OP_DIV) || (i_op == MD_OP_DIVU);
        is_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
        s1        = is_signed & i_dato1[len-1];
        s2        = is_signed & i_dato2[len-1];
        a_mag     = s1 ? -i_dato1 : i_dato1;
        b_mag     = s2 ? -i_dato2 : i_dato2;
        div_zero  = is_div && (i_dato2 == '0);
        go        = (state == ST_IDLE) && i_start && !i_flush;
        prod      = neg_q ? -{acc, wlo} : {acc, wlo};
    end

    muldiv_step #(.len(len)) u_step (
        .is_div  (op_div),
        .acc     (acc),
        .lo      (wlo),
        .opnd    (opnd),
        .nxt_acc (nxt_acc),
        .nxt_lo  (nxt_lo)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            wlo    <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        op_div <= is_div;
                        cnt    <= '0;
                        if (div_zero) begin
                            // preload the fixed divide-by-zero result, no signs applied
                            state <= ST_FIX;
                            acc   <= i_dato1;
                            wlo   <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            acc   <= '0;
                            wlo   <= is_div ? a_mag : b_mag;
                            opnd  <= is_div ? b_mag : a_mag;
                            neg_q <= s1 ^ s2;
                            neg_r <= is_div & s1;
                        end
                    end else if (!i_start) begin
                        if (i_wr_hi) hi_q <= i_wdata;
                        if (i_wr_lo) lo_q <= i_wdata;
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= nxt_acc;
                        wlo <= nxt_lo;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(len - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!i_flush) begin
                        done_q <= 1'b1;
                        if (op_div) begin
                            lo_q <= neg_q ? -wlo : wlo;
                            hi_q <= neg_r ? -acc : acc;
                        end else begin
                            {hi_q, lo_q} <= prod;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_busy  = (state != ST_IDLE);
    assign o_stall = o_busy || go;
    assign o_done  = done_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Randomized bench for ex_muldiv_ctrl against a 64-bit arithmetic reference.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_flush, i_wr_hi, i_wr_lo;
    logic [1:0]  i_op;
    logic [31:0] i_dato1, i_dato2, i_wdata;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_stall, o_done;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mhi, mlo;

    ex_muldiv_ctrl dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
        .i_dato1(i_dato1), .i_dato2(i_dato2), .i_flush(i_flush),
        .i_wr_hi(i_wr_hi), .i_wr_lo(i_wr_lo), .i_wdata(i_wdata),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!i_rst) assert (!(o_busy && i_start)) else $error("FAIL start_while_busy");

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed/unsigned arithmetic (truncating division).
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = sa * sb; {h, l} = p; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mtlo_mid);
        logic [31:0] eh, el;
        int nbusy;
        model(op, a, b, eh, el);
        @(negedge clk);
        i_start = 1; i_op = op; i_dato1 = a; i_dato2 = b;
        #1 chk("stall_on_start", o_stall, 1);
        @(negedge clk);
        i_start = 0; i_dato1 = $urandom; i_dato2 = $urandom;
        nbusy = 0;
        while (o_busy && nbusy < 100) begin
            nbusy++;
            if (nbusy == 1) chk("stall_busy", o_stall, 1);
            if (mtlo_mid && nbusy == 3) begin i_wr_lo = 1; i_wdata = $urandom; end
            else i_wr_lo = 0;
            @(negedge clk);
        end
        i_wr_lo = 0;
        chk("busy_cycles", nbusy, (op[1] && b == 0) ? 1 : 33);
        chk("done_pulse", o_done, 1);
        chk("hi", o_hi, eh);
        chk("lo", o_lo, el);
        @(negedge clk);
        chk("done_clear", o_done, 0);
        mhi = eh; mlo = el;
    endtask

    task automatic mt_write(input bit whi, input bit wlo, input logic [31:0] d);
        @(negedge clk);
        i_wr_hi = whi; i_wr_lo = wlo; i_wdata = d;
        @(negedge clk);
        i_wr_hi = 0; i_wr_lo = 0;
        if (whi) mhi = d;
        if (wlo) mlo = d;
        chk("mt_hi", o_hi, mhi);
        chk("mt_lo", o_lo, mlo);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        i_rst = 1; i_start = 0; i_flush = 0; i_wr_hi = 0; i_wr_lo = 0;
        i_op = 0; i_dato1 = 0; i_dato2 = 0; i_wdata = 0;
        mhi = 0; mlo = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_hi", o_hi, 0);
        chk("rst_lo", o_lo, 0);
        chk("rst_done", o_done, 0);
        chk("rst_stall", o_stall, 0);
        i_rst = 0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b11, 32'd100, 32'd0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'h1234_5678, 32'd0, 0);

        // MTHI, then flush a MULTU at iteration 10
        mt_write(1, 0, 32'h1234_5678);
        @(negedge clk);
        i_start = 1; i_op = 2'b01; i_dato1 = 5; i_dato2 = 6;
        @(negedge clk);
        i_start = 0;
        repeat (10) @(negedge clk);
        i_flush = 1;
        @(negedge clk);
        i_flush = 0;
        chk("flush_busy", o_busy, 0);
        chk("flush_stall", o_stall, 0);
        chk("flush_done", o_done, 0);
        chk("flush_hi", o_hi, 32'h1234_5678);
        @(negedge clk);
        chk("flush_done2", o_done, 0);
        chk("flush_lo", o_lo, mlo);

        // start and flush together in IDLE
        @(negedge clk);
        i_start = 1; i_flush = 1; i_op = 2'b00; i_dato1 = 3; i_dato2 = 4;
        #1 chk("stflush_stall", o_stall, 0);
        @(negedge clk);
        i_start = 0; i_flush = 0;
        chk("stflush_busy", o_busy, 0);
        @(negedge clk);
        chk("stflush_done", o_done, 0);
        chk("stflush_hi", o_hi, mhi);

        mt_write(1, 1, 32'hCAFE_F00D);
        run_op(2'b00, 32'd123, 32'hFFFF_FF00, 1);

        // reset mid-RUN
        @(negedge clk);
        i_start = 1; i_op = 2'b11; i_dato1 = 32'hDEAD_BEEF; i_dato2 = 32'd13;
        @(negedge clk);
        i_start = 0;
        repeat (5) @(negedge clk);
        i_rst = 1;
        @(negedge clk);
        i_rst = 0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_hi", o_hi, 0);
        chk("midrst_lo", o_lo, 0);
        chk("midrst_done", o_done, 0);
        mhi = 0; mlo = 0;

        for (int n = 0; n < 20; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                3: b = $urandom_range(1, 3);
                default: ;
            endcase
            run_op(op, a, b, n[2]);
            if (n % 5 == 4) mt_write($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Iterative multiply/divide sequencer for the execute stage. Accepts MULT/MULTU/DIV/DIVU from decode, runs a one-bit-per-cycle shift-add / restoring-divide loop, and holds the 64-bit result in HI/LO. It stalls the pipeline while an operation is in flight and services MTHI/MTLO writes. It sits beside the execute-stage ALU and feeds MFHI/MFLO through the existing result mux.

## Interface
- len, 32, operand width; HI and LO are each len bits
- NB_MD_OP, 2, width of operation code
- i_clk  in  1  clock; all registers update on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  decode presents a mul/div operation this cycle
- i_op  in  NB_MD_OP  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_dato1  in  len  rs operand: multiplicand or dividend
- i_dato2  in  len  rt operand: multiplier or divisor
- i_flush  in  1  kill the in-flight operation (branch/exception)
- i_wr_hi  in  1  MTHI write strobe
- i_wr_lo  in  1  MTLO write strobe
- i_wdata  in  len  MTHI/MTLO data
- o_hi  out  len  HI register
- o_lo  out  len  LO register
- o_busy  out  1  registered; high while state is not IDLE
- o_stall  out  1  combinational: o_busy OR (state==IDLE AND i_start AND NOT i_flush)
- o_done  out  1  one-cycle pulse in the cycle after HI/LO receive a mul/div result

## Operation
- States:
  - IDLE: accepting operations.
  - RUN: len iterations.
  - FIX: sign correction and HI/LO write.
- IDLE → RUN on i_start AND NOT i_flush, when the divisor is non-zero or the op is a multiply.
  - On this transition, latch operand magnitudes, the result-sign flags and the op type, and clear the iteration counter.
- IDLE → FIX on a DIV/DIVU start with i_dato2 == 0. Skips the loop.
- RUN, each cycle:
  - Perform one step.
  - Multiply: conditional add of the multiplicand into the upper half, then shift the {acc, multiplier} pair right.
  - Divide: shift {rem, quot} left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - Increment the counter. RUN → FIX after the step with counter == len-1.
- FIX:
  - Write HI/LO, then go to IDLE and pulse o_done on the next cycle.
  - Multiply: {HI,LO} = 2len-bit product, negated when MULT operand signs differ.
  - Divide: LO = quotient, negated when DIV operand signs differ. HI = remainder with the sign of the dividend.
  - Unsigned ops never negate.
- Divide by zero: LO = all ones, HI = i_dato1 unchanged, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic; no special case.
- i_flush in RUN or FIX: go to IDLE next edge, HI/LO unchanged, no o_done. i_flush has priority over i_start in IDLE.
- i_start while o_busy: ignored. The bench asserts it never occurs.
- i_wr_hi / i_wr_lo: honoured only in IDLE with i_start low; ignored otherwise. Both may fire in the same cycle.
- Reset (any state, including mid-operation): state IDLE, counter 0, o_hi = o_lo = 0, o_busy = 0, o_done = 0. Working registers are cleared.

## Timing
- Start accepted at edge k.
- Normal op:
  - o_busy is high in cycles k+1 .. k+len+1, i.e. len+1 cycles.
  - HI/LO are valid after edge k+len+1.
  - o_done is high in cycle k+len+2 (k+len+1 .. k+len+2).
- Divide by zero:
  - o_busy is high for 1 cycle only.
  - HI/LO are valid after edge k+1.
  - o_done is high in the cycle after edge k+1.
- o_stall is high in cycle k (combinational on i_start) and in every busy cycle, so decode holds the following instruction.
- MTHI/MTLO: result visible one cycle after the strobe edge.
- MFHI/MFLO issued while o_stall is high are held by the pipeline. The unit never returns a partial result.

## Structure
- Shared package holds:
  - MD_OP_MULT / MULTU / DIV / DIVU encodings
  - state encoding (IDLE, RUN, FIX)
  - the counter width constant, clog2(len)
- One natural sub-module: muldiv_step, combinational.
  - Inputs: op type, {acc, lo} working pair, magnitude operand.
  - Outputs: next working pair for one iteration.
  - ex_muldiv_ctrl keeps the FSM, counter, sign logic, HI/LO and the stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; o_busy for 33 cycles; single o_done pulse.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064 after 2 cycles. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678 then MULTU 5×6 with i_flush at iteration 10 → state IDLE next cycle, HI still 0x12345678, no o_done, o_stall low.
- i_rst asserted mid-RUN → next cycle o_busy=0, o_hi=o_lo=0. i_start together with i_flush in IDLE → no operation starts.
- MTLO while busy → ignored, LO = operation result. i_start while busy → the bench assertion fires.
